// File: rtl/fpmul_sched.sv
// rtl/fpmul_sched.sv - round-robin issue scheduler and result tagger for a shared pipelined multiplier
module fpmul_sched #(
    parameter int LAT  = 6,
    parameter int NREQ = 3,
    parameter int CW   = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [NREQ-1:0] REQ,
    input  logic            HOLD,
    input  logic            FLUSH,
    output logic [NREQ-1:0] GNT,
    output logic            ISSUE,
    output logic [1:0]      SEL,
    output logic [NREQ-1:0] RES_VLD,
    output logic [CW-1:0]   INFLIGHT,
    output logic            BUSY
);

    // The RES_VLD register itself is the last tag stage, so only LAT-1 stages are kept here.
    localparam int TS = LAT - 1;

    logic [1:0]         ptr;
    logic [1:0]         ptr_nxt;
    logic [TS-1:0]      tag_vld;
    logic [TS-1:0][1:0] tag_idx;
    logic [NREQ-1:0]    res_nxt;
    logic [2:0]         sum;
    logic [1:0]         idx;
    logic               found;

    // Round-robin search starting at ptr; grants are masked by HOLD, FLUSH and reset.
    always_comb begin
        GNT   = '0;
        SEL   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + 3'(k);
            if (sum >= 3'(NREQ)) begin
                sum = sum - 3'(NREQ);
            end
            idx = sum[1:0];
            if (!found && REQ[idx]) begin
                found    = 1'b1;
                GNT[idx] = 1'b1;
                SEL      = idx;
            end
        end
        if (HOLD || FLUSH || !RST_N) begin
            GNT = '0;
            SEL = '0;
        end
    end

    assign ISSUE   = |GNT;
    assign BUSY    = (INFLIGHT != '0) || ISSUE;
    assign ptr_nxt = (SEL == 2'(NREQ - 1)) ? 2'd0 : SEL + 2'd1;

    always_comb begin
        res_nxt = '0;
        if (tag_vld[TS-1]) begin
            res_nxt[tag_idx[TS-1]] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr <= '0;
        end else if (ISSUE) begin
            ptr <= ptr_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tag_vld <= '0;
            tag_idx <= '0;
            RES_VLD <= '0;
        end else begin
            tag_vld[0] <= ISSUE;
            tag_idx[0] <= SEL;
            for (int s = 1; s < TS; s++) begin
                tag_vld[s] <= tag_vld[s-1] & ~FLUSH;
                tag_idx[s] <= tag_idx[s-1];
            end
            RES_VLD <= FLUSH ? '0 : res_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            INFLIGHT <= '0;
        end else if (FLUSH) begin
            INFLIGHT <= '0;
        end else begin
            case ({ISSUE, |RES_VLD})
                2'b10:   INFLIGHT <= INFLIGHT + CW'(1);
                2'b01:   INFLIGHT <= INFLIGHT - CW'(1);
                default: INFLIGHT <= INFLIGHT;
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_sched.sv
// tb/tb_fpmul_sched.sv - directed self-checking bench for fpmul_sched
module tb_fpmul_sched;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic [2:0] REQ = '0;
    logic       HOLD = 1'b0;
    logic       FLUSH = 1'b0;
    logic [2:0] GNT;
    logic       ISSUE;
    logic [1:0] SEL;
    logic [2:0] RES_VLD;
    logic [3:0] INFLIGHT;
    logic       BUSY;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] req;
        logic [2:0] gnt;
        logic [1:0] sel;
        logic [2:0] res;
        logic [3:0] infl;
    } vec_t;

    vec_t tbl [16];

    always #5 CLK = ~CLK;

    fpmul_sched #(.LAT(6), .NREQ(3), .CW(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .HOLD(HOLD), .FLUSH(FLUSH),
        .GNT(GNT), .ISSUE(ISSUE), .SEL(SEL), .RES_VLD(RES_VLD),
        .INFLIGHT(INFLIGHT), .BUSY(BUSY)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string nm, input logic [2:0] g, input logic [1:0] s,
                           input logic [2:0] r, input logic [3:0] n);
        chk({nm, ".gnt"}, 32'(GNT), 32'(g));
        chk({nm, ".sel"}, 32'(SEL), 32'(s));
        chk({nm, ".issue"}, 32'(ISSUE), 32'(g != 3'b000));
        chk({nm, ".res_vld"}, 32'(RES_VLD), 32'(r));
        chk({nm, ".inflight"}, 32'(INFLIGHT), 32'(n));
        chk({nm, ".busy"}, 32'(BUSY), 32'((n != 4'd0) || (g != 3'b000)));
    endtask

    task automatic step(input logic [2:0] r, input logic h, input logic f);
        @(posedge CLK);
        #1;
        REQ   = r;
        HOLD  = h;
        FLUSH = f;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        HOLD  = 1'b0;
        FLUSH = 1'b0;
        REQ   = 3'b111;
        RST_N = 1'b0;
        #1;
        chk_out("reset", 3'b000, 2'd0, 3'b000, 4'd0);
        @(negedge CLK);
        REQ   = 3'b000;
        RST_N = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{3'b111, 3'b001, 2'd0, 3'b000, 4'd0};
        tbl[1]  = '{3'b111, 3'b010, 2'd1, 3'b000, 4'd1};
        tbl[2]  = '{3'b111, 3'b100, 2'd2, 3'b000, 4'd2};
        tbl[3]  = '{3'b111, 3'b001, 2'd0, 3'b000, 4'd3};
        tbl[4]  = '{3'b111, 3'b010, 2'd1, 3'b000, 4'd4};
        tbl[5]  = '{3'b111, 3'b100, 2'd2, 3'b000, 4'd5};
        tbl[6]  = '{3'b111, 3'b001, 2'd0, 3'b001, 4'd6};
        tbl[7]  = '{3'b111, 3'b010, 2'd1, 3'b010, 4'd6};
        tbl[8]  = '{3'b111, 3'b100, 2'd2, 3'b100, 4'd6};
        tbl[9]  = '{3'b000, 3'b000, 2'd0, 3'b001, 4'd6};
        tbl[10] = '{3'b000, 3'b000, 2'd0, 3'b010, 4'd5};
        tbl[11] = '{3'b000, 3'b000, 2'd0, 3'b100, 4'd4};
        tbl[12] = '{3'b000, 3'b000, 2'd0, 3'b001, 4'd3};
        tbl[13] = '{3'b000, 3'b000, 2'd0, 3'b010, 4'd2};
        tbl[14] = '{3'b000, 3'b000, 2'd0, 3'b100, 4'd1};
        tbl[15] = '{3'b000, 3'b000, 2'd0, 3'b000, 4'd0};

        // saturation
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].req, 1'b0, 1'b0);
            chk_out($sformatf("sat[%0d]", i), tbl[i].gnt, tbl[i].sel, tbl[i].res, tbl[i].infl);
        end

        // single request
        do_reset();
        step(3'b001, 1'b0, 1'b0);
        chk_out("single[0]", 3'b001, 2'd0, 3'b000, 4'd0);
        for (int k = 1; k <= 7; k++) begin
            step(3'b000, 1'b0, 1'b0);
            chk_out($sformatf("single[%0d]", k), 3'b000, 2'd0,
                    (k == 6) ? 3'b001 : 3'b000, (k <= 6) ? 4'd1 : 4'd0);
        end

        // fairness: requester 0 held, requester 2 joins at cycle 3
        do_reset();
        for (int c = 0; c < 6; c++) begin
            step((c == 3) ? 3'b101 : 3'b001, 1'b0, 1'b0);
            chk_out($sformatf("fair[%0d]", c), (c == 3) ? 3'b100 : 3'b001,
                    (c == 3) ? 2'd2 : 2'd0, 3'b000, 4'(c));
        end

        // hold
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(3'b010, 1'b1, 1'b0);
            chk_out($sformatf("hold[%0d]", c), 3'b000, 2'd0, 3'b000, 4'd0);
        end
        step(3'b010, 1'b0, 1'b0);
        chk_out("hold_rel", 3'b010, 2'd1, 3'b000, 4'd0);
        step(3'b000, 1'b0, 1'b0);
        chk_out("hold_after", 3'b000, 2'd0, 3'b000, 4'd1);

        // flush: three issues leave ptr at 1, flush with REQ=100
        do_reset();
        step(3'b011, 1'b0, 1'b0);
        chk_out("fl_i0", 3'b001, 2'd0, 3'b000, 4'd0);
        step(3'b011, 1'b0, 1'b0);
        chk_out("fl_i1", 3'b010, 2'd1, 3'b000, 4'd1);
        step(3'b011, 1'b0, 1'b0);
        chk_out("fl_i2", 3'b001, 2'd0, 3'b000, 4'd2);
        step(3'b000, 1'b0, 1'b0);
        chk_out("fl_gap", 3'b000, 2'd0, 3'b000, 4'd3);
        step(3'b100, 1'b0, 1'b1);
        chk_out("fl_pulse", 3'b000, 2'd0, 3'b000, 4'd3);
        for (int c = 0; c < 8; c++) begin
            step(3'b000, 1'b0, 1'b0);
            chk_out($sformatf("fl_drain[%0d]", c), 3'b000, 2'd0, 3'b000, 4'd0);
        end
        step(3'b111, 1'b0, 1'b0);
        chk_out("fl_next", 3'b010, 2'd1, 3'b000, 4'd0);
        for (int k = 1; k <= 7; k++) begin
            step(3'b000, 1'b0, 1'b0);
            chk_out($sformatf("fl_res[%0d]", k), 3'b000, 2'd0,
                    (k == 6) ? 3'b010 : 3'b000, (k <= 6) ? 4'd1 : 4'd0);
        end

        // reset mid-flight
        do_reset();
        step(3'b111, 1'b0, 1'b0);
        chk_out("rst_i0", 3'b001, 2'd0, 3'b000, 4'd0);
        step(3'b111, 1'b0, 1'b0);
        chk_out("rst_i1", 3'b010, 2'd1, 3'b000, 4'd1);
        step(3'b111, 1'b0, 1'b0);
        chk_out("rst_i2", 3'b100, 2'd2, 3'b000, 4'd2);
        step(3'b111, 1'b0, 1'b0);
        chk_out("rst_i3", 3'b001, 2'd0, 3'b000, 4'd3);
        step(3'b000, 1'b0, 1'b0);
        chk_out("rst_pre", 3'b000, 2'd0, 3'b000, 4'd4);
        #2;
        REQ   = 3'b111;
        RST_N = 1'b0;
        #1;
        chk_out("rst_async", 3'b000, 2'd0, 3'b000, 4'd0);
        @(negedge CLK);
        REQ   = 3'b000;
        RST_N = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step(3'b000, 1'b0, 1'b0);
            chk_out($sformatf("rst_post[%0d]", c), 3'b000, 2'd0, 3'b000, 4'd0);
        end
        step(3'b111, 1'b0, 1'b0);
        chk_out("rst_ptr", 3'b001, 2'd0, 3'b000, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
